mss_ahb_capture_slave: RTL
==========================

// Module: mss_ahb_capture_slave
// PURPOSE
//  AHB-lite fabric slave on the MSS master port (MSSH* bus, FAB_CLK domain) exposing NUM_CH
//  independent capture channels. Each channel buffers 32-bit words from a fabric producer in a
//  FIFO that firmware drains via register reads. A threshold/overflow interrupt drives FABINT.
// PARAMETERS
//  NUM_CH      2   number of capture channels, 1..16
//  FIFO_DEPTH  16  words per channel FIFO, power of two, 2..256
//  ADDR_W      20  MSSHADDR width
// PORTS
//  FAB_CLK      in   1           fabric clock, all logic rising-edge
//  M2F_RESET_N  in   1           asynchronous active-low reset
//  MSSHADDR     in   ADDR_W      AHB address
//  MSSHTRANS    in   2           AHB transfer type; bit1=1 means NONSEQ/SEQ
//  MSSHSIZE     in   2           AHB size; only 2'b10 (word) is legal
//  MSSHWRITE    in   1           1=write
//  MSSHWDATA    in   32          write data (data phase)
//  MSSHRDATA    out  32          read data, registered
//  MSSHREADY    out  1           slave ready
//  MSSHRESP     out  1           0=OKAY, 1=ERROR
//  FABINT       out  1           level interrupt to MSS, registered
//  ch_valid     in   NUM_CH      per-channel word strobe
//  ch_data      in   32*NUM_CH   per-channel word; channel c at [32c+31:32c]
//  ch_ready     out  NUM_CH      channel c = enable_c & !full_c (from registered state)
// BEHAVIOUR
//  Reset: MSSHRDATA=0, MSSHREADY=1, MSSHRESP=0, FABINT=0, ch_ready=0; all CTRL=0, THRESH=1,
//   FIFOs empty, sticky flags clear. Reset mid-transfer aborts the transfer; no partial write.
//  Address decode: ch=ADDR[11:8], off=ADDR[7:0], ADDR[ADDR_W-1:12] must be 0.
//   Per-channel registers:
//   0x00 CTRL   RW  [0] enable, [1] irq_en, [2] flush (write-1 pulse, reads 0)
//   0x04 STATUS R   [15:0] count, [16] empty, [17] full, [25] thr_hit; [24] overflow (W1C)
//   0x08 DATA   R   pops FIFO head; empty -> returns 0, no pop, OKAY
//   0x0C THRESH RW  [15:0] threshold; thr_hit = count >= THRESH and THRESH != 0
//   Other offsets: read 0, write ignored, OKAY.
//  Transfer accepted at an edge where MSSHTRANS[1]=1 and MSSHREADY=1. Address, ch, off and
//   write are latched for the data phase. IDLE/BUSY: no access, OKAY, zero wait.
//  ERROR if ch >= NUM_CH, upper address bits nonzero, or MSSHSIZE != 2'b10:
//   cycle 1 READY=0 RESP=1; cycle 2 READY=1 RESP=1; no state change, no pop.
//  Write: zero wait. Register updated at the end of the data phase from MSSHWDATA.
//  Read: exactly one wait state. Data-phase cycle 1 READY=0; at its end MSSHRDATA is loaded
//   from current state, including a write completed in the previous cycle, and a DATA pop
//   takes effect. Cycle 2 READY=1. Back-to-back reads: 2 cycles each.
//  FIFO push: at an edge where ch_valid & enable & (!full | pop_same_edge). Push and pop on the
//   same edge leave count unchanged and keep order. ch_valid & enable & full & no pop sets
//   overflow and drops the word. Disabled channel ignores ch_valid and keeps its contents.
//  Flush: pointers and count go to 0 on the write edge; a same-edge push is discarded; overflow
//   is not cleared. Flush and overflow W1C in one STATUS/CTRL sequence are independent.
//  Overflow W1C coinciding with a new overflow event: set wins.
//  Pointers: log2(FIFO_DEPTH) bits, wrap modulo depth. count: log2(FIFO_DEPTH)+1 bits,
//   zero-extended to 16.
//  FABINT registered: next value = OR over c of irq_en_c & (thr_hit_c | overflow_c).
//   Latency is 1 FAB_CLK after the condition.
// TESTING
//  Reset -> RDATA=0, READY=1, RESP=0, FABINT=0, ch_ready=0; read CH0 THRESH=1, STATUS=0x00010000.
//  Enable ch0, push 0xA1,0xA2,0xA3 -> STATUS count=3; three DATA reads return A1,A2,A3 in order;
//   a 4th read returns 0 and STATUS empty=1.
//  DEPTH=16: push 17 words, no reads -> full=1, overflow=1, count=16; write STATUS bit24=1 ->
//   overflow=0; DATA reads return words 1..16.
//  Read 0x200 with NUM_CH=2, and a halfword read of 0x004 -> two-cycle ERROR, FIFO count unchanged.
//  THRESH=4, irq_en=1: push 3 -> FABINT=0; 4th push -> FABINT=1 next cycle; one DATA read -> 0.
//  Full FIFO, ch_valid on the DATA pop edge -> no overflow, count stays 16; assert flush then
//   reset mid-read -> all reset values restored.

Source files
------------

// File: rtl/mss_ahb_capture_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mss_ahb_capture_slave                                         |
// | Purpose  : AHB-lite slave on the MSS master port exposing NUM_CH capture |
// |            channels. Each channel buffers 32-bit producer words in a     |
// |            FIFO that firmware drains through register reads; a           |
// |            threshold/overflow interrupt drives FABINT.                   |
// | Ports    : FAB_CLK, M2F_RESET_N (async, active low)                      |
// |            MSSHADDR/TRANS/SIZE/WRITE/WDATA  AHB request in               |
// |            MSSHRDATA/READY/RESP             AHB response out             |
// |            FABINT                           level interrupt, registered  |
// |            ch_valid/ch_data in, ch_ready out  per-channel producer side  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mss_ahb_capture_slave #(
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 20
) (
  input  logic                     FAB_CLK,
  input  logic                     M2F_RESET_N,
  input  logic [ADDR_W-1:0]        MSSHADDR,
  input  logic [1:0]               MSSHTRANS,
  input  logic [1:0]               MSSHSIZE,
  input  logic                     MSSHWRITE,
  input  logic [31:0]              MSSHWDATA,
  output logic [31:0]              MSSHRDATA,
  output logic                     MSSHREADY,
  output logic                     MSSHRESP,
  output logic                     FABINT,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [32*NUM_CH-1:0]     ch_data,
  output logic [NUM_CH-1:0]        ch_ready
);

  localparam int c_PW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam logic [7:0]      c_OFF_CTRL   = 8'h00;
  localparam logic [7:0]      c_OFF_STATUS = 8'h04;
  localparam logic [7:0]      c_OFF_DATA   = 8'h08;
  localparam logic [7:0]      c_OFF_THRESH = 8'h0C;
  localparam logic [c_CW-1:0] c_CNT_FULL   = c_CW'(FIFO_DEPTH);
  localparam logic [c_CW-1:0] c_CNT_ONE    = c_CW'(1);
  localparam logic [c_PW-1:0] c_PTR_ONE    = c_PW'(1);

  // Data-phase tracker. RD1/ER1 are the wait cycles (READY low).
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD1  = 3'd2,
    S_RD2  = 3'd3,
    S_ER1  = 3'd4,
    S_ER2  = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_ch;
  logic [7:0]        r_off;
  logic [31:0]       r_rdata;
  logic              r_fabint;

  logic [NUM_CH-1:0] r_en;
  logic [NUM_CH-1:0] r_irq_en;
  logic [NUM_CH-1:0] r_ovf;
  logic [15:0]       r_thr [NUM_CH];
  logic [c_PW-1:0]   r_wp  [NUM_CH];
  logic [c_PW-1:0]   r_rp  [NUM_CH];
  logic [c_CW-1:0]   r_cnt [NUM_CH];
  logic [31:0]       r_mem [NUM_CH][FIFO_DEPTH];

  logic              w_accept;
  logic              w_addr_err;
  logic [31:0]       w_rd_word;
  logic [NUM_CH-1:0] w_wr_sel;
  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_empty;
  logic [NUM_CH-1:0] w_thr_hit;
  logic [NUM_CH-1:0] w_pop;
  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_ovf_set;
  logic [NUM_CH-1:0] w_ovf_clr;
  logic [NUM_CH-1:0] w_flush;
  logic              w_unused;

  // NONSEQ and SEQ are treated alike; unused write-data bits are ignored.
  assign w_unused = ^{MSSHTRANS[0], MSSHWDATA[31:25], MSSHWDATA[23:16]};

  assign w_accept   = MSSHTRANS[1] & MSSHREADY;
  assign w_addr_err = ({1'b0, MSSHADDR[11:8]} >= 5'(NUM_CH))
                    | (|MSSHADDR[ADDR_W-1:12])
                    | (MSSHSIZE != 2'b10);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      r_state <= S_IDLE;
      r_ch    <= 4'd0;
      r_off   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_ch  <= MSSHADDR[11:8];
        r_off <= MSSHADDR[7:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    MSSHREADY   = 1'b1;
    MSSHRESP    = 1'b0;
    if (w_accept) begin
      if (w_addr_err)     w_state_nxt = S_ER1;
      else if (MSSHWRITE) w_state_nxt = S_WR;
      else                w_state_nxt = S_RD1;
    end else begin
      case (r_state)
        S_RD1:   w_state_nxt = S_RD2;
        S_ER1:   w_state_nxt = S_ER2;
        default: w_state_nxt = S_IDLE;
      endcase
    end
    case (r_state)
      S_RD1: MSSHREADY = 1'b0;
      S_ER1: begin MSSHREADY = 1'b0; MSSHRESP = 1'b1; end
      S_ER2: MSSHRESP = 1'b1;
      default: ;
    endcase
  end

  // ------------------------------------------------- per-channel decode
  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic w_hit;
      logic w_push_req;
      assign w_hit        = (r_ch == 4'(c));
      assign w_wr_sel[c]  = (r_state == S_WR) && w_hit;
      assign w_full[c]    = (r_cnt[c] == c_CNT_FULL);
      assign w_empty[c]   = (r_cnt[c] == '0);
      assign w_thr_hit[c] = (r_thr[c] != 16'd0) && (16'(r_cnt[c]) >= r_thr[c]);
      assign w_pop[c]     = (r_state == S_RD1) && w_hit && (r_off == c_OFF_DATA) && !w_empty[c];
      assign w_flush[c]   = w_wr_sel[c] && (r_off == c_OFF_CTRL) && MSSHWDATA[2];
      assign w_ovf_clr[c] = w_wr_sel[c] && (r_off == c_OFF_STATUS) && MSSHWDATA[24];
      assign w_push_req   = ch_valid[c] & r_en[c];
      // A full FIFO still accepts a word when the head leaves on the same edge.
      assign w_push[c]    = w_push_req & (!w_full[c] | w_pop[c]) & !w_flush[c];
      assign w_ovf_set[c] = w_push_req & w_full[c] & !w_pop[c];
      assign ch_ready[c]  = r_en[c] & !w_full[c];
    end
  endgenerate

  // ------------------------------------------- channel control and FIFO
  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      r_en     <= '0;
      r_irq_en <= '0;
      r_ovf    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_thr[c] <= 16'd1;
        r_wp[c]  <= '0;
        r_rp[c]  <= '0;
        r_cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_wr_sel[c] && (r_off == c_OFF_CTRL)) begin
          r_en[c]     <= MSSHWDATA[0];
          r_irq_en[c] <= MSSHWDATA[1];
        end
        if (w_wr_sel[c] && (r_off == c_OFF_THRESH))
          r_thr[c] <= MSSHWDATA[15:0];
        // A fresh overflow event beats a simultaneous W1C.
        if (w_ovf_set[c])
          r_ovf[c] <= 1'b1;
        else if (w_ovf_clr[c])
          r_ovf[c] <= 1'b0;
        if (w_flush[c]) begin
          r_wp[c]  <= '0;
          r_rp[c]  <= '0;
          r_cnt[c] <= '0;
        end else begin
          if (w_push[c]) r_wp[c] <= r_wp[c] + c_PTR_ONE;
          if (w_pop[c])  r_rp[c] <= r_rp[c] + c_PTR_ONE;
          if (w_push[c] && !w_pop[c])
            r_cnt[c] <= r_cnt[c] + c_CNT_ONE;
          else if (!w_push[c] && w_pop[c])
            r_cnt[c] <= r_cnt[c] - c_CNT_ONE;
        end
      end
    end
  end

  // Storage is not reset: the pointers and count define what is valid.
  always_ff @(posedge FAB_CLK) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_push[c])
        r_mem[c][r_wp[c]] <= ch_data[32*c +: 32];
    end
  end

  // ------------------------------------------------------- read mux
  always_comb begin
    w_rd_word = 32'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_ch == 4'(c)) begin
        case (r_off)
          c_OFF_CTRL:   w_rd_word = {29'd0, 1'b0, r_irq_en[c], r_en[c]};
          c_OFF_STATUS: w_rd_word = {6'd0, w_thr_hit[c], r_ovf[c], 6'd0,
                                     w_full[c], w_empty[c], 16'(r_cnt[c])};
          c_OFF_DATA:   w_rd_word = w_empty[c] ? 32'd0 : r_mem[c][r_rp[c]];
          c_OFF_THRESH: w_rd_word = {16'd0, r_thr[c]};
          default:      w_rd_word = 32'd0;
        endcase
      end
    end
  end

  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      r_rdata  <= 32'd0;
      r_fabint <= 1'b0;
    end else begin
      if (r_state == S_RD1)
        r_rdata <= w_rd_word;
      r_fabint <= |(r_irq_en & (w_thr_hit | r_ovf));
    end
  end

  assign MSSHRDATA = r_rdata;
  assign FABINT    = r_fabint;

endmodule
`default_nettype wire
